// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI target endpoint.
package spi_target_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_SHIFT,
    ST_WAIT_DESELECT
  } spi_state_e;

  // Widest word the default idle pattern covers.
  localparam int          TX_IDLE_MAX_WIDTH = 64;
  localparam logic [63:0] TX_IDLE_ALL_ONES  = '1;

endpackage

// File: rtl/spi_target_pin_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin with registered
// rise/fall pulses. The level output is taken from the same delay register
// the edge compare uses, so a pin's level and its edge pulses stay aligned.
module spi_pin_sync #(
  parameter int   STAGES      = 2,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              dly;

  // Synchronizer chain, one extra delay stage and registered edge pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= {STAGES{RESET_LEVEL}};
      dly  <= RESET_LEVEL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], pin};
      dly  <= sync[STAGES-1];
      rise <= sync[STAGES-1] & ~dly;
      fall <= ~sync[STAGES-1] & dly;
    end
  end

  assign level = dly;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target, MSB first, oversampled in the io_clock domain.
// Received words leave on a valid/ready stream; words to send arrive on a
// second valid/ready stream through a one-word holding register.
// The pad-level IOBUF is driven with T = ~io_spi_misoEn and I = io_spi_miso.
//
//   state            | meaning
//   -----------------+--------------------------------------------------
//   ST_IDLE          | deselected, waiting for ss to fall
//   ST_ARMED         | reserved encoding, never entered; falls back to IDLE
//   ST_SHIFT         | frame active, shifting on sclk edges
//   ST_WAIT_DESELECT | after reset: wait for ss high before accepting frames
module spi_target
  import spi_target_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] TX_IDLE     = TX_IDLE_ALL_ONES[DATA_WIDTH-1:0]
) (
  input  logic                  io_clock,
  input  logic                  io_reset,
  input  logic                  io_spi_sclk,
  input  logic                  io_spi_ss,
  input  logic                  io_spi_mosi,
  output logic                  io_spi_miso,
  output logic                  io_spi_misoEn,
  output logic                  io_rx_valid,
  input  logic                  io_rx_ready,
  output logic [DATA_WIDTH-1:0] io_rx_payload,
  input  logic                  io_tx_valid,
  output logic                  io_tx_ready,
  input  logic [DATA_WIDTH-1:0] io_tx_payload,
  output logic                  io_status_overrun,
  output logic                  io_status_underrun,
  input  logic                  io_status_clear
);

  localparam int                CNT_W    = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam int                SETTLE   = SYNC_STAGES + 1;
  localparam int                SETTLE_W = $clog2(SETTLE + 1);

  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic ss_level, ss_rise, ss_fall;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_sclk_sync (
    .clk   (io_clock),
    .rst   (io_reset),
    .pin   (io_spi_sclk),
    .level (sclk_level_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_LEVEL(1'b1)) u_ss_sync (
    .clk   (io_clock),
    .rst   (io_reset),
    .pin   (io_spi_ss),
    .level (ss_level),
    .rise  (ss_rise),
    .fall  (ss_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_mosi_sync (
    .clk   (io_clock),
    .rst   (io_reset),
    .pin   (io_spi_mosi),
    .level (mosi_level),
    .rise  (mosi_rise_unused),
    .fall  (mosi_fall_unused)
  );

  spi_state_e                state, state_next;
  logic [SETTLE_W-1:0]       settle_cnt;
  logic                      settle_done;
  logic                      start_frame, drop_frame, rx_step, tx_step;
  logic [CNT_W-1:0]          bit_cnt;
  logic                      reload;
  logic [DATA_WIDTH-2:0]     rx_shift;
  logic [DATA_WIDTH-1:0]     rx_word;
  logic                      word_done;
  logic [DATA_WIDTH-2:0]     tx_shift;
  logic [DATA_WIDTH-1:0]     tx_word;
  logic                      tx_load, tx_accept;
  logic                      tx_hold_full;
  logic [DATA_WIDTH-1:0]     tx_hold;
  logic                      miso, miso_en;
  logic                      rx_valid;
  logic [DATA_WIDTH-1:0]     rx_payload;
  logic                      overrun, underrun;
  logic                      overrun_set, underrun_set;

  // The synchronizers come out of reset claiming ss=1; the real pin level
  // only reaches ss_level SETTLE cycles later, so WAIT_DESELECT must not
  // trust ss_level before this down-counter hits its terminal count.
  always_ff @(posedge io_clock) begin
    if (io_reset) begin
      settle_cnt <= SETTLE_W'(SETTLE);
    end else if (settle_cnt != '0) begin
      settle_cnt <= settle_cnt - SETTLE_W'(1);
    end
  end

  assign settle_done = (settle_cnt == '0);

  // State register.
  always_ff @(posedge io_clock) begin
    if (io_reset) begin
      state <= ST_WAIT_DESELECT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-cycle frame controls; ss rise outranks a
  // coincident sclk fall so a frame's closing edge does not load a word.
  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    drop_frame  = 1'b0;
    rx_step     = 1'b0;
    tx_step     = 1'b0;
    if (ss_rise) begin
      state_next = ST_IDLE;
      drop_frame = 1'b1;
    end else begin
      case (state)
        ST_WAIT_DESELECT: begin
          if (settle_done && ss_level) state_next = ST_IDLE;
        end
        ST_IDLE: begin
          if (ss_fall) begin
            state_next  = ST_SHIFT;
            start_frame = 1'b1;
          end
        end
        ST_SHIFT: begin
          rx_step = sclk_rise;
          tx_step = sclk_fall;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign rx_word      = {rx_shift, mosi_level};
  assign word_done    = rx_step && (bit_cnt == LAST_BIT);
  assign tx_load      = start_frame | (tx_step & reload);
  assign tx_word      = tx_hold_full ? tx_hold : TX_IDLE;
  assign tx_accept    = io_tx_valid & ~tx_hold_full;
  assign underrun_set = tx_load & ~tx_hold_full;
  assign overrun_set  = word_done & rx_valid & ~io_rx_ready;

  // Shift datapath: bit counter, RX/TX shifters and the registered MISO pin.
  // tx_shift holds only the bits still to send; the MSB goes straight to MISO.
  always_ff @(posedge io_clock) begin
    if (io_reset) begin
      miso     <= 1'b0;
      miso_en  <= 1'b0;
      bit_cnt  <= '0;
      reload   <= 1'b0;
      rx_shift <= '0;
      tx_shift <= '0;
    end else if (drop_frame) begin
      miso     <= 1'b0;
      miso_en  <= 1'b0;
      bit_cnt  <= '0;
      reload   <= 1'b0;
    end else if (start_frame) begin
      tx_shift <= tx_word[DATA_WIDTH-2:0];
      miso     <= tx_word[DATA_WIDTH-1];
      miso_en  <= 1'b1;
      bit_cnt  <= '0;
      reload   <= 1'b0;
    end else if (rx_step) begin
      rx_shift <= rx_word[DATA_WIDTH-2:0];
      if (bit_cnt == LAST_BIT) begin
        bit_cnt <= '0;
        reload  <= 1'b1;
      end else begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end else if (tx_step) begin
      if (reload) begin
        tx_shift <= tx_word[DATA_WIDTH-2:0];
        miso     <= tx_word[DATA_WIDTH-1];
        reload   <= 1'b0;
      end else begin
        tx_shift <= tx_shift << 1;
        miso     <= tx_shift[DATA_WIDTH-2];
      end
    end
  end

  // TX holding register; a word accepted during a load waits for the next one.
  always_ff @(posedge io_clock) begin
    if (io_reset) begin
      tx_hold_full <= 1'b0;
      tx_hold      <= '0;
    end else begin
      if (tx_accept) tx_hold <= io_tx_payload;
      if (tx_load) begin
        tx_hold_full <= tx_accept;
      end else if (tx_accept) begin
        tx_hold_full <= 1'b1;
      end
    end
  end

  // RX holding register; a completed word is dropped only if the old one stays.
  always_ff @(posedge io_clock) begin
    if (io_reset) begin
      rx_valid   <= 1'b0;
      rx_payload <= '0;
    end else if (word_done && (!rx_valid || io_rx_ready)) begin
      rx_valid   <= 1'b1;
      rx_payload <= rx_word;
    end else if (rx_valid && io_rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

  // Sticky status flags; a set in the same cycle as a clear wins.
  always_ff @(posedge io_clock) begin
    if (io_reset) begin
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      overrun  <= overrun_set  | (overrun  & ~io_status_clear);
      underrun <= underrun_set | (underrun & ~io_status_clear);
    end
  end

  assign io_spi_miso        = miso;
  assign io_spi_misoEn      = miso_en;
  assign io_rx_valid        = rx_valid;
  assign io_rx_payload      = rx_payload;
  assign io_tx_ready        = ~tx_hold_full;
  assign io_status_overrun  = overrun;
  assign io_status_underrun = underrun;

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: drives a mode-0 controller at io_clock/16, checks MISO
// bit streams directly and received words through an expected-word queue.
module tb_spi_target;

  localparam int HALF = 8;

  logic       clk, rst;
  logic       sclk, ss, mosi;
  logic       miso, miso_en;
  logic       rx_valid, rx_ready;
  logic [7:0] rx_payload;
  logic       tx_valid, tx_ready;
  logic [7:0] tx_payload;
  logic       ovr, und, clr;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] sb_rx[$];
  logic [15:0] cap;

  spi_target dut (
    .io_clock           (clk),
    .io_reset           (rst),
    .io_spi_sclk        (sclk),
    .io_spi_ss          (ss),
    .io_spi_mosi        (mosi),
    .io_spi_miso        (miso),
    .io_spi_misoEn      (miso_en),
    .io_rx_valid        (rx_valid),
    .io_rx_ready        (rx_ready),
    .io_rx_payload      (rx_payload),
    .io_tx_valid        (tx_valid),
    .io_tx_ready        (tx_ready),
    .io_tx_payload      (tx_payload),
    .io_status_overrun  (ovr),
    .io_status_underrun (und),
    .io_status_clear    (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pop and compare each word the consumer accepts.
  always @(negedge clk) begin
    #1;
    if (!rst && rx_valid && rx_ready) begin
      if (sb_rx.size() == 0) check_val("rx_extra", sb_rx.size(), 1);
      else check_val("rx_word", rx_payload, sb_rx.pop_front());
    end
  end

  task automatic tx_push(input logic [7:0] w);
    check_val("tx_ready", tx_ready, 1);
    tx_valid   = 1'b1;
    tx_payload = w;
    wait_clk(1);
    tx_valid   = 1'b0;
  endtask

  task automatic clear_flags();
    clr = 1'b1;
    wait_clk(1);
    clr = 1'b0;
  endtask

  // Mode-0 frame: data MSB first, ss released together with the last sclk fall.
  task automatic spi_xfer(input logic [15:0] data, input int nbits, input bit chk_lat,
                          output logic [15:0] got);
    got  = '0;
    ss   = 1'b0;
    mosi = data[15];
    if (chk_lat) begin
      wait_clk(3);
      check_val("lat_en_early", miso_en, 0);
      wait_clk(1);
      check_val("lat_en", miso_en, 1);
      wait_clk(HALF - 4);
    end else begin
      wait_clk(HALF);
    end
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b1;
      if (i == 0) check_val("frame_en", miso_en, 1);
      got = {got[14:0], miso};
      wait_clk(HALF);
      sclk = 1'b0;
      if (i == nbits - 1) ss = 1'b1;
      else mosi = data[14-i];
      wait_clk(HALF);
    end
    mosi = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic sclk_pulse();
    sclk = 1'b1;
    wait_clk(HALF);
    sclk = 1'b0;
    wait_clk(HALF);
  endtask

  initial begin
    rst = 1'b1; ss = 1'b0; sclk = 1'b0; mosi = 1'b0;
    rx_ready = 1'b1; tx_valid = 1'b0; tx_payload = '0; clr = 1'b0;

    // reset values, ss held low throughout
    wait_clk(3);
    check_val("rst_miso", miso, 0);
    check_val("rst_miso_en", miso_en, 0);
    check_val("rst_rx_valid", rx_valid, 0);
    check_val("rst_rx_payload", rx_payload, 0);
    check_val("rst_tx_ready", tx_ready, 1);
    check_val("rst_overrun", ovr, 0);
    check_val("rst_underrun", und, 0);
    rst = 1'b0;
    wait_clk(20);
    check_val("wait_deselect_en", miso_en, 0);
    ss = 1'b1;
    wait_clk(10);

    // single word
    tx_push(8'hA5);
    sb_rx.push_back(8'h3C);
    spi_xfer(16'h3C00, 8, 1'b1, cap);
    check_val("single_miso", cap[7:0], 8'hA5);
    check_val("single_en_off", miso_en, 0);
    check_val("single_underrun", und, 0);
    check_val("single_overrun", ovr, 0);
    check_val("single_drained", sb_rx.size(), 0);

    // underrun in a two-word frame
    tx_push(8'h5A);
    sb_rx.push_back(8'h12);
    sb_rx.push_back(8'h34);
    spi_xfer(16'h1234, 16, 1'b0, cap);
    check_val("underrun_miso", cap, 16'h5AFF);
    check_val("underrun_flag", und, 1);
    check_val("underrun_no_ovr", ovr, 0);
    clear_flags();
    check_val("underrun_clear", und, 0);

    // overrun with consumer stalled
    rx_ready = 1'b0;
    sb_rx.push_back(8'h11);
    spi_xfer(16'h1122, 16, 1'b0, cap);
    check_val("overrun_valid", rx_valid, 1);
    check_val("overrun_payload", rx_payload, 8'h11);
    check_val("overrun_flag", ovr, 1);
    rx_ready = 1'b1;
    wait_clk(1);
    check_val("overrun_valid_drop", rx_valid, 0);
    clear_flags();
    check_val("overrun_clear", ovr, 0);
    check_val("overrun_und_clear", und, 0);

    // abort after 5 bits, then a clean frame
    spi_xfer(16'hF000, 5, 1'b0, cap);
    check_val("abort_en", miso_en, 0);
    check_val("abort_valid", rx_valid, 0);
    wait_clk(10);
    tx_push(8'h96);
    sb_rx.push_back(8'hC3);
    spi_xfer(16'hC300, 8, 1'b0, cap);
    check_val("post_abort_miso", cap[7:0], 8'h96);

    // reset during bit 3 with ss held low
    ss = 1'b0;
    mosi = 1'b1;
    wait_clk(HALF);
    sclk_pulse();
    sclk_pulse();
    sclk = 1'b1;
    wait_clk(2);
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(HALF);
    sclk = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 5; i++) sclk_pulse();
    check_val("midrst_en", miso_en, 0);
    check_val("midrst_valid", rx_valid, 0);
    ss = 1'b1;
    wait_clk(10);
    sb_rx.push_back(8'h81);
    spi_xfer(16'h8100, 8, 1'b0, cap);
    check_val("midrst_miso", cap[7:0], 8'hFF);
    check_val("midrst_underrun", und, 1);

    wait_clk(10);
    check_val("sb_drained", sb_rx.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
